// File: rtl/usb_tx_packetizer_if.sv
// rtl/usb_tx_packetizer_if.sv - packet request, payload stream and line outputs of the USB transmitter
interface usb_tx_packetizer_if #(
   parameter int MAX_BYTES = 64
);
   localparam int CW = $clog2(MAX_BYTES + 1);

   logic          start;
   logic [3:0]    pid;
   logic          append_crc;
   logic [CW-1:0] byte_count;
   logic [7:0]    data_in;
   logic          data_valid;
   logic          data_ready;
   logic          dplus_out;
   logic          dminus_out;
   logic          busy;
   logic          tx_done;
   logic          tx_error;

   modport master (
      output start, pid, append_crc, byte_count, data_in, data_valid,
      input  data_ready, dplus_out, dminus_out, busy, tx_done, tx_error
   );

   modport slave (
      input  start, pid, append_crc, byte_count, data_in, data_valid,
      output data_ready, dplus_out, dminus_out, busy, tx_done, tx_error
   );
endinterface

// File: rtl/usb_tx_packetizer.sv
// rtl/usb_tx_packetizer.sv - full-speed USB packet serializer with stuffing, NRZI, CRC16 and EOP
module usb_tx_packetizer #(
   parameter int CLKS_PER_BIT = 8,
   parameter int MAX_BYTES    = 64,
   parameter int CRC_EN       = 1
) (
   input  logic               clk,
   input  logic               n_rst,
   usb_tx_packetizer_if.slave bus
);
   localparam int CW   = $clog2(MAX_BYTES + 1);
   localparam int CNTW = $clog2(CLKS_PER_BIT);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]   LEN_MAX  = CW'(MAX_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J
   } state_t;

   state_t          state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [4:0]      idx_q, idx_d;
   logic [2:0]      ones_q, ones_d;
   logic [15:0]     crc_q, crc_d;
   logic [3:0]      pid_q, pid_d;
   logic            crc_on_q, crc_on_d;
   logic [CW-1:0]   len_q, len_d;
   logic [CW-1:0]   fetched_q, fetched_d;
   logic [CW-1:0]   loaded_q, loaded_d;
   logic [7:0]      hold_q, hold_d;
   logic            hold_full_q, hold_full_d;
   logic            err_q, err_d;
   logic            dplus_q, dplus_d;
   logic            dminus_q, dminus_d;
   logic            tx_done_q, tx_done_d;
   logic            tx_error_q, tx_error_d;

   state_t          eff_state;
   logic [7:0]      eff_shreg;
   logic [4:0]      eff_idx;
   logic            raw_bit;
   logic            ready;
   logic            xfer;
   logic            stuff_field;

   assign ready = ((state_q == S_PID) || (state_q == S_DATA)) && !hold_full_q && (fetched_q != len_q);
   assign xfer  = bus.data_valid && ready;
   assign stuff_field = (state_q == S_SYNC) || (state_q == S_PID) ||
                        (state_q == S_DATA) || (state_q == S_CRC);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shreg_d     = shreg_q;
      idx_d       = idx_q;
      ones_d      = ones_q;
      crc_d       = crc_q;
      pid_d       = pid_q;
      crc_on_d    = crc_on_q;
      len_d       = len_q;
      fetched_d   = fetched_q;
      loaded_d    = loaded_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      err_d       = err_q;
      dplus_d     = dplus_q;
      dminus_d    = dminus_q;
      tx_done_d   = 1'b0;
      tx_error_d  = 1'b0;
      eff_state   = state_q;
      eff_shreg   = shreg_q;
      eff_idx     = idx_q;
      raw_bit     = 1'b0;

      if (xfer) begin
         hold_d      = bus.data_in;
         hold_full_d = 1'b1;
         fetched_d   = fetched_q + 1'b1;
      end

      if (state_q == S_IDLE) begin
         cnt_d = '0;
         // The cycle that reports tx_done must not also launch a packet
         if (bus.start && !tx_done_q) begin
            state_d     = S_SYNC;
            shreg_d     = 8'h80;
            idx_d       = 5'd0;
            ones_d      = 3'd0;
            crc_d       = 16'hFFFF;
            pid_d       = bus.pid;
            crc_on_d    = bus.append_crc && (CRC_EN != 0);
            len_d       = (bus.byte_count > LEN_MAX) ? LEN_MAX : bus.byte_count;
            fetched_d   = '0;
            loaded_d    = '0;
            hold_full_d = 1'b0;
            err_d       = 1'b0;
         end
      end else begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
         if (cnt_q == '0) begin
            if (stuff_field && (ones_q == 3'd6)) begin
               dplus_d  = ~dplus_q;
               dminus_d = dplus_q;
               ones_d   = 3'd0;
            end else begin
               // Settle which field this bit time belongs to before emitting it
               case (state_q)
                  S_SYNC: if (idx_q == 5'd8) begin
                     eff_state = S_PID;
                     eff_shreg = {~pid_q, pid_q};
                     eff_idx   = 5'd0;
                  end
                  S_PID, S_DATA: if (idx_q == 5'd8) begin
                     eff_idx = 5'd0;
                     if (loaded_q != len_q) begin
                        if (hold_full_q || xfer) begin
                           eff_state   = S_DATA;
                           eff_shreg   = hold_full_q ? hold_q : bus.data_in;
                           hold_full_d = 1'b0;
                           loaded_d    = loaded_q + 1'b1;
                        end else begin
                           eff_state = S_EOP_SE0;
                           err_d     = 1'b1;
                        end
                     end else begin
                        eff_state = crc_on_q ? S_CRC : S_EOP_SE0;
                     end
                  end
                  S_CRC: if (idx_q == 5'd16) begin
                     eff_state = S_EOP_SE0;
                     eff_idx   = 5'd0;
                  end
                  S_EOP_SE0: if (idx_q == 5'd2) begin
                     eff_state = S_EOP_J;
                     eff_idx   = 5'd0;
                  end
                  default: ;
               endcase

               state_d = eff_state;
               shreg_d = eff_shreg;
               idx_d   = eff_idx + 5'd1;

               case (eff_state)
                  S_SYNC, S_PID, S_DATA: begin
                     raw_bit = eff_shreg[0];
                     shreg_d = {1'b0, eff_shreg[7:1]};
                  end
                  S_CRC: begin
                     raw_bit = ~crc_q[15];
                     crc_d   = {crc_q[14:0], 1'b0};
                  end
                  default: ;
               endcase

               case (eff_state)
                  S_SYNC, S_PID, S_DATA, S_CRC: begin
                     if (!raw_bit) begin
                        dplus_d  = ~dplus_q;
                        dminus_d = dplus_q;
                     end
                     ones_d = raw_bit ? ones_q + 3'd1 : 3'd0;
                     if (eff_state == S_DATA) begin
                        crc_d = {crc_q[14:0], 1'b0} ^ ((raw_bit ^ crc_q[15]) ? 16'h8005 : 16'h0000);
                     end
                  end
                  S_EOP_SE0: begin
                     dplus_d  = 1'b0;
                     dminus_d = 1'b0;
                  end
                  S_EOP_J: begin
                     if (eff_idx == 5'd0) begin
                        dplus_d  = 1'b1;
                        dminus_d = 1'b0;
                     end else begin
                        state_d    = S_IDLE;
                        idx_d      = eff_idx;
                        tx_done_d  = 1'b1;
                        tx_error_d = err_q;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         shreg_q     <= 8'h00;
         idx_q       <= 5'd0;
         ones_q      <= 3'd0;
         crc_q       <= 16'hFFFF;
         pid_q       <= 4'h0;
         crc_on_q    <= 1'b0;
         len_q       <= '0;
         fetched_q   <= '0;
         loaded_q    <= '0;
         hold_q      <= 8'h00;
         hold_full_q <= 1'b0;
         err_q       <= 1'b0;
         dplus_q     <= 1'b1;
         dminus_q    <= 1'b0;
         tx_done_q   <= 1'b0;
         tx_error_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         idx_q       <= idx_d;
         ones_q      <= ones_d;
         crc_q       <= crc_d;
         pid_q       <= pid_d;
         crc_on_q    <= crc_on_d;
         len_q       <= len_d;
         fetched_q   <= fetched_d;
         loaded_q    <= loaded_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         err_q       <= err_d;
         dplus_q     <= dplus_d;
         dminus_q    <= dminus_d;
         tx_done_q   <= tx_done_d;
         tx_error_q  <= tx_error_d;
      end
   end

   assign bus.data_ready = ready;
   assign bus.dplus_out  = dplus_q;
   assign bus.dminus_out = dminus_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.tx_done    = tx_done_q;
   assign bus.tx_error   = tx_error_q;
endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb/tb_usb_tx_packetizer.sv - randomized bench for usb_tx_packetizer against a bit-list line model
module tb_usb_tx_packetizer;
   localparam int CPB  = 8;
   localparam int MAXB = 64;
   localparam int CW   = $clog2(MAXB + 1);

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   bit   exp_dp[$];
   bit   exp_dm[$];
   logic [7:0] pay [0:127];

   usb_tx_packetizer_if #(.MAX_BYTES(MAXB)) bus ();

   usb_tx_packetizer #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB), .CRC_EN(1)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Expected line symbol per bit time: raw fields, then stuffing, NRZI and EOP
   task automatic build_model(input logic [3:0] p, input int nsent, input bit use_crc);
      bit raw[$];
      logic [15:0] c;
      logic [7:0] pb;
      bit line;
      bit d;
      int ones;
      exp_dp.delete();
      exp_dm.delete();
      c = 16'hFFFF;
      for (int i = 0; i < 8; i++) raw.push_back(i == 7);
      pb = {~p, p};
      for (int i = 0; i < 8; i++) raw.push_back(pb[i]);
      for (int n = 0; n < nsent; n++) begin
         for (int i = 0; i < 8; i++) begin
            d = pay[n][i];
            raw.push_back(d);
            if (d ^ c[15]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else           c = {c[14:0], 1'b0};
         end
      end
      if (use_crc) for (int i = 15; i >= 0; i--) raw.push_back(~c[i]);
      line = 1'b1;
      ones = 0;
      foreach (raw[i]) begin
         if (!raw[i]) line = ~line;
         exp_dp.push_back(line);
         exp_dm.push_back(~line);
         ones = raw[i] ? ones + 1 : 0;
         if (ones == 6) begin
            line = ~line;
            exp_dp.push_back(line);
            exp_dm.push_back(~line);
            ones = 0;
         end
      end
      exp_dp.push_back(1'b0); exp_dm.push_back(1'b0);
      exp_dp.push_back(1'b0); exp_dm.push_back(1'b0);
      exp_dp.push_back(1'b1); exp_dm.push_back(1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      n_rst = 1'b0;
      bus.data_valid = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic run_pkt(input string tag, input logic [3:0] p, input int bc, input bit ac,
                          input int supply, input int maxgap, input bit mid_start,
                          output int done_edge);
      int nsent, tend, guard, err_before, k;
      bit exp_err, bad, err_at_done, busy_at_done;
      logic [1:0] line_at_done;
      err_before = errors;
      nsent = (bc > MAXB) ? MAXB : bc;
      if (supply < nsent) begin
         exp_err = 1'b1;
         build_model(p, supply, 1'b0);
      end else begin
         exp_err = 1'b0;
         build_model(p, nsent, ac);
      end
      tend = 1 + exp_dp.size() * CPB;
      @(negedge clk);
      bus.start = 1'b1;
      bus.pid = p;
      bus.append_crc = ac;
      bus.byte_count = CW'(bc);
      bus.data_valid = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
      done_edge = -1;
      bad = 1'b0;
      err_at_done = 1'b0;
      busy_at_done = 1'b1;
      line_at_done = 2'b00;
      fork
         begin : drv
            for (int n = 0; n < supply; n++) begin
               repeat ($urandom_range(0, maxgap)) @(negedge clk);
               bus.data_in = pay[n];
               bus.data_valid = 1'b1;
               guard = 0;
               while (!bus.data_ready && guard < 3000) begin
                  @(negedge clk);
                  guard++;
               end
               if (guard >= 3000) begin
                  checks++;
                  errors++;
                  $display("FAIL %s_ready_timeout: byte %0d never accepted", tag, n);
                  break;
               end
               @(negedge clk);
            end
            bus.data_valid = 1'b0;
         end
         begin : chk
            for (int e = 1; e <= tend + 4 * CPB && done_edge < 0; e++) begin
               @(negedge clk);
               if (mid_start && e == 40) begin bus.start = 1'b1; bus.pid = ~p; end
               if (mid_start && e == 41) begin bus.start = 1'b0; bus.pid = p; end
               if (bus.tx_done) begin
                  done_edge = e;
                  err_at_done = bus.tx_error;
                  busy_at_done = bus.busy;
                  line_at_done = {bus.dplus_out, bus.dminus_out};
               end else if (!bad && e < tend) begin
                  k = (e - 1) / CPB;
                  checks++;
                  if ({bus.dplus_out, bus.dminus_out} !== {exp_dp[k], exp_dm[k]}) begin
                     errors++;
                     bad = 1'b1;
                     $display("FAIL %s_line bit %0d edge %0d: got %b%b required %b%b",
                              tag, k, e, bus.dplus_out, bus.dminus_out, exp_dp[k], exp_dm[k]);
                  end
               end
            end
         end
      join
      check({tag, "_done_edge"}, done_edge, tend);
      check({tag, "_tx_error"}, {31'd0, err_at_done}, {31'd0, exp_err});
      check({tag, "_busy_fall"}, {31'd0, busy_at_done}, 32'd0);
      check({tag, "_eop_j"}, {30'd0, line_at_done}, 32'd2);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, "_start_at_done_ignored"}, {31'd0, bus.busy}, 32'd0);
      check({tag, "_done_one_cycle"}, {31'd0, bus.tx_done}, 32'd0);
      if (errors != err_before) do_reset();
   endtask

   initial begin
      int de, n, tg;
      logic [18:0] v;
      bus.start = 1'b0;
      bus.pid = 4'h0;
      bus.append_crc = 1'b0;
      bus.byte_count = '0;
      bus.data_in = 8'h00;
      bus.data_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dplus", {31'd0, bus.dplus_out}, 32'd1);
      check("rst_dminus", {31'd0, bus.dminus_out}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_ready", {31'd0, bus.data_ready}, 32'd0);
      check("rst_done", {31'd0, bus.tx_done}, 32'd0);
      check("rst_error", {31'd0, bus.tx_error}, 32'd0);
      n_rst = 1'b1;

      build_model(4'h2, 0, 1'b0);
      for (int i = 0; i < 19; i++) v[i] = exp_dp[i];
      check("model_ack_len", exp_dp.size(), 32'd19);
      check("model_ack_dplus", {13'd0, v}, {13'd0, 19'b100_00011011_00101010});
      build_model(4'h3, 0, 1'b1);
      check("model_zlp_len", exp_dp.size(), 32'd35);
      tg = 0;
      for (int i = 16; i < 32; i++) if (exp_dp[i] != exp_dp[i-1]) tg++;
      check("model_zlp_crc_toggles", tg, 32'd16);

      run_pkt("ack", 4'h2, 0, 1'b0, 0, 0, 1'b1, de);
      check("ack_done_153", de, 32'd153);
      run_pkt("zlp", 4'h3, 0, 1'b1, 0, 0, 1'b0, de);
      check("zlp_done_281", de, 32'd281);

      pay[0] = 8'hFF; pay[1] = 8'hFF;
      run_pkt("ff_ff", 4'hB, 2, 1'b1, 2, 0, 1'b0, de);

      for (int i = 0; i < 4; i++) pay[i] = 8'(i);
      run_pkt("crc_gaps", 4'h3, 4, 1'b1, 4, 3, 1'b0, de);

      pay[0] = 8'($urandom);
      run_pkt("underrun", 4'hB, 3, 1'b1, 1, 0, 1'b0, de);

      for (int i = 0; i < MAXB; i++) pay[i] = 8'($urandom);
      run_pkt("clamp", 4'h3, MAXB + 5, 1'b1, MAXB, 1, 1'b0, de);

      repeat (4) begin
         n = $urandom_range(0, 6);
         for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
         run_pkt("rand", 4'($urandom), n, 1'($urandom_range(0, 1)), n, 3, 1'b0, de);
      end

      @(negedge clk);
      bus.start = 1'b1;
      bus.pid = 4'h3;
      bus.append_crc = 1'b1;
      bus.byte_count = CW'(4);
      bus.data_in = 8'h55;
      bus.data_valid = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (200) @(negedge clk);
      check("mid_rst_busy_before", {31'd0, bus.busy}, 32'd1);
      #2 n_rst = 1'b0;
      #1;
      check("mid_rst_dplus", {31'd0, bus.dplus_out}, 32'd1);
      check("mid_rst_dminus", {31'd0, bus.dminus_out}, 32'd0);
      check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("mid_rst_ready", {31'd0, bus.data_ready}, 32'd0);
      check("mid_rst_done", {31'd0, bus.tx_done}, 32'd0);
      @(negedge clk);
      bus.data_valid = 1'b0;
      n_rst = 1'b1;

      run_pkt("post_rst_ack", 4'h2, 0, 1'b0, 0, 0, 1'b0, de);
      check("post_rst_done_153", de, 32'd153);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
